// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button event path.
package button_pkg;

  // Press tracking states used by press_event_controller.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } press_state_t;

  // Defaults for a 100 MHz clock: 1.5 s long-press threshold, 0.25 s repeat.
  localparam int DEFAULT_CNT_W         = 28;
  localparam int DEFAULT_LONG_CYCLES   = 150_000_000;
  localparam int DEFAULT_REPEAT_CYCLES = 25_000_000;

endpackage : button_pkg

// File: rtl/press_repeat_timer.sv
// Free-running period counter that emits a one-cycle tick every PERIOD
// enabled cycles; clear restarts the count from zero.
module press_repeat_timer #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  // Counter holds 0..PERIOD-1; the tick fires on the cycle it would reach PERIOD.
  localparam int             CW   = (PERIOD < 1) ? 1 : $clog2(PERIOD + 1);
  localparam logic [CW-1:0]  LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Count enabled cycles and pulse the tick at the end of each period.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset || i_clear) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_enable) begin
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule : press_repeat_timer

// File: rtl/press_event_controller.sv
// Turns a debounced button level into press/short/long/repeat/release pulses
// and a saturating hold count for the counter state machine.
module press_event_controller
  import button_pkg::*;
#(
  parameter int CNT_W         = DEFAULT_CNT_W,
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             btn_i,
  output logic             press_evt,
  output logic             short_evt,
  output logic             long_evt,
  output logic             repeat_evt,
  output logic             release_evt,
  output logic [CNT_W-1:0] hold_count,
  output logic             long_active
);

  localparam logic [CNT_W-1:0] LONG_VAL = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_MAX = '1;

  press_state_t     r_state;
  press_state_t     w_next_state;
  logic             r_btn_q;
  logic             r_seen_low;
  logic [CNT_W-1:0] r_hold_count;
  logic [CNT_W-1:0] w_next_hold;
  logic             r_press_evt;
  logic             r_short_evt;
  logic             r_long_evt;
  logic             r_release_evt;
  logic             r_long_active;
  logic             w_press;
  logic             w_short;
  logic             w_long;
  logic             w_release;
  logic             w_rep_clear;
  logic             w_rep_enable;
  logic             w_repeat_tick;

  // State, hold count, sampled button and registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_btn_q       <= 1'b0;
      r_seen_low    <= 1'b0;
      r_hold_count  <= '0;
      r_press_evt   <= 1'b0;
      r_short_evt   <= 1'b0;
      r_long_evt    <= 1'b0;
      r_release_evt <= 1'b0;
      r_long_active <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_btn_q       <= btn_i;
      // btn_q reads 0 after reset without a real sample behind it; a level
      // held through reset must not look like a rising edge.
      r_seen_low    <= r_seen_low | ~btn_i;
      r_hold_count  <= w_next_hold;
      r_press_evt   <= w_press;
      r_short_evt   <= w_short;
      r_long_evt    <= w_long;
      r_release_evt <= w_release;
      r_long_active <= (w_next_state == LONG);
    end
  end

  // Next-state, next hold count and event decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_next_state = r_state;
    w_next_hold  = r_hold_count;
    w_press      = 1'b0;
    w_short      = 1'b0;
    w_long       = 1'b0;
    w_release    = 1'b0;

    if (!en) begin
      // Abort silently: no release for a press that was cut off.
      w_next_state = IDLE;
      w_next_hold  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_next_hold = '0;
          if (btn_i && !r_btn_q && r_seen_low) begin
            w_next_state = PRESS;
            w_next_hold  = CNT_W'(1);
            w_press      = 1'b1;
          end
        end
        PRESS: begin
          if (btn_i) begin
            w_next_hold = r_hold_count + CNT_W'(1);
            if (w_next_hold == LONG_VAL) begin
              w_next_state = LONG;
              w_long       = 1'b1;
            end
          end else begin
            w_next_state = IDLE;
            w_next_hold  = '0;
            w_short      = 1'b1;
            w_release    = 1'b1;
          end
        end
        LONG: begin
          if (btn_i) begin
            if (r_hold_count != HOLD_MAX) begin
              w_next_hold = r_hold_count + CNT_W'(1);
            end
          end else begin
            w_next_state = IDLE;
            w_next_hold  = '0;
            w_release    = 1'b1;
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_hold  = '0;
        end
      endcase
    end
  end

  // Repeat timer runs only while long-held; it restarts on every entry to LONG.
  assign w_rep_clear  = !en || (r_state != LONG);
  assign w_rep_enable = (r_state == LONG) && btn_i;

  press_repeat_timer #(
    .PERIOD (REPEAT_CYCLES)
  ) u_repeat_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_rep_clear),
    .i_enable (w_rep_enable),
    .o_tick   (w_repeat_tick)
  );

  assign press_evt   = r_press_evt;
  assign short_evt   = r_short_evt;
  assign long_evt    = r_long_evt;
  assign repeat_evt  = w_repeat_tick;
  assign release_evt = r_release_evt;
  assign hold_count  = r_hold_count;
  assign long_active = r_long_active;

endmodule : press_event_controller
